ro_freq_counter: RTL and testbench

- Measures the frequency of the selected ring oscillator.
- Sits directly downstream of the 16:1 ring-oscillator mux in the user project wrapper: it takes the muxed oscillator output and drives the mux select and the oscillator start line.
- Counts synchronized rising edges of the oscillator over a programmable gate window of clock cycles.
- Configured and read back by the management core through a Wishbone slave; raises an interrupt on completion.

---
 rtl/ro_freq_counter.sv | 164 ++++++++++++++++
 tb/tb_ro_freq_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter with a Wishbone slave.
// Counts synchronized rising edges of the muxed oscillator over a programmable gate window.
module ro_freq_counter #(
  parameter logic [31:0] BASE_ADR      = 32'h3000_0000,
  parameter int unsigned COUNT_W       = 32,
  parameter int unsigned GATE_W        = 32,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        ro_in,
  output logic [3:0]  ro_sel,
  output logic        ro_start,
  output logic        irq
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StDone} state_e;

  state_e               state_q;
  logic                 ack_q;
  logic [31:0]          rdat_q;
  logic                 ro_en_q, irq_en_q;
  logic [3:0]           sel_q;
  logic [GATE_W-1:0]    gate_q, gate_cnt_q;
  logic [COUNT_W-1:0]   counter_q, count_res_q;
  logic [SettleW-1:0]   settle_q;
  logic                 busy_q, done_q, ovf_q;
  logic                 s1_q, s2_q, s3_q;

  logic                 addr_hit, access, wr, rd;
  logic [1:0]           offset;
  logic                 ctrl_wr, gate_wr, status_wr, rise;
  logic [31:0]          gate_ext, gate_new, rdata;

  assign addr_hit  = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign access    = wbs_stb_i & wbs_cyc_i & addr_hit & ~ack_q;
  assign wr        = access & wbs_we_i;
  assign rd        = access & ~wbs_we_i;
  assign offset    = wbs_adr_i[3:2];
  assign ctrl_wr   = wr && (offset == 2'd0) && wbs_sel_i[0];
  assign gate_wr   = wr && (offset == 2'd1);
  assign status_wr = wr && (offset == 2'd3) && wbs_sel_i[0];
  assign rise      = s2_q & ~s3_q;
  assign gate_ext  = 32'(gate_q);

  // Byte-lane merge of a GATE write onto the current value.
  always_comb begin
    gate_new = gate_ext;
    for (int b = 0; b < 4; b++) begin
      if (wbs_sel_i[b]) gate_new[8*b +: 8] = wbs_dat_i[8*b +: 8];
    end
  end

  // Register read mux; go always reads back as 0.
  always_comb begin
    rdata = '0;
    case (offset)
      2'd0:    rdata = {24'b0, sel_q, 1'b0, irq_en_q, 1'b0, ro_en_q};
      2'd1:    rdata = gate_ext;
      2'd2:    rdata = 32'(count_res_q);
      default: rdata = {29'b0, ovf_q, done_q, busy_q};
    endcase
  end

  // Bus interface, register file, synchronizer and measurement FSM.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= StIdle;
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      ro_en_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      sel_q       <= '0;
      gate_q      <= '0;
      gate_cnt_q  <= '0;
      counter_q   <= '0;
      count_res_q <= '0;
      settle_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
    end else begin
      ack_q  <= access;
      rdat_q <= rd ? rdata : 32'b0;
      s1_q   <= ro_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;

      // Mux select, enable and gate are frozen while a measurement runs.
      if (ctrl_wr) begin
        irq_en_q <= wbs_dat_i[2];
        if (!busy_q) begin
          ro_en_q <= wbs_dat_i[0];
          sel_q   <= wbs_dat_i[7:4];
        end
      end
      if (gate_wr && !busy_q) gate_q <= gate_new[GATE_W-1:0];

      // Write-1-to-clear; FSM assignments below take priority.
      if (status_wr) begin
        if (wbs_dat_i[1]) done_q <= 1'b0;
        if (wbs_dat_i[2]) ovf_q  <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (ctrl_wr && wbs_dat_i[1]) begin
            state_q   <= StSettle;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            counter_q <= '0;
            settle_q  <= '0;
          end
        end
        StSettle: begin
          settle_q <= settle_q + SettleW'(1);
          if (settle_q == SettleW'(SETTLE_CYCLES - 1)) begin
            if (gate_q == '0) begin
              state_q <= StDone;
            end else begin
              state_q    <= StMeasure;
              gate_cnt_q <= gate_q;
            end
          end
        end
        StMeasure: begin
          if (rise) begin
            if (counter_q == {COUNT_W{1'b1}}) ovf_q <= 1'b1;
            else                              counter_q <= counter_q + COUNT_W'(1);
          end
          gate_cnt_q <= gate_cnt_q - GATE_W'(1);
          if (gate_cnt_q == GATE_W'(1)) state_q <= StDone;
        end
        default: begin
          count_res_q <= counter_q;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign ro_sel    = sel_q;
  assign ro_start  = ro_en_q;
  assign irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed self-checking bench for ro_freq_counter (8-bit counter instance).
module tb_ro_freq_counter;

  localparam logic [31:0] Base = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        ro_in;
  logic [3:0]  ro_sel;
  logic        ro_start, irq;

  int  n_checks = 0;
  int  n_errors = 0;
  int  ro_half = 0;
  time t_ack = 0;
  bit  irq_watch = 0, irq_seen = 0;

  ro_freq_counter #(
    .BASE_ADR(Base), .COUNT_W(8), .GATE_W(32), .SETTLE_CYCLES(4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .ro_in(ro_in), .ro_sel(ro_sel), .ro_start(ro_start), .irq(irq)
  );

  always #5 clk = ~clk;

  // Oscillator model: toggles every ro_half clocks, held low when ro_half is 0.
  initial begin
    int cnt;
    cnt = 0;
    ro_in = 1'b0;
    forever begin
      @(negedge clk);
      if (ro_half == 0) begin
        ro_in = 1'b0;
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= ro_half) begin
          ro_in = ~ro_in;
          cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) if (irq_watch && irq) irq_seen = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [3:0] off, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    bit got;
    got = 0;
    r = '0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = Base | 32'(off); wdat = d; sel = s;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1;
        break;
      end
    end
    r = rdat;
    t_ack = $time;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check_eq("ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    check_eq("ack_single", 32'(ack), 32'd0);
  endtask

  task automatic wb_wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused;
    wb_xfer(1'b1, off, d, s, unused);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, off, 32'h0, 4'hF, r);
    check_eq(tag, r, exp);
  endtask

  // Cycles from the go ack edge to irq rising, or -1 on timeout.
  task automatic wait_irq(input time t0, input int limit, output int cycles);
    cycles = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (irq) begin
        cycles = int'(($time - t0) / 10);
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    time  t_go;
    logic [31:0] r;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check_eq("rst_irq", 32'(irq), 0);
    check_eq("rst_start", 32'(ro_start), 0);
    check_eq("rst_sel", 32'(ro_sel), 0);
    rd_chk("rst_ctrl", 4'h0, 32'h0);
    rd_chk("rst_gate", 4'h4, 32'h0);
    rd_chk("rst_count", 4'h8, 32'h0);
    rd_chk("rst_status", 4'hC, 32'h0);

    // Register access and byte lanes
    wb_wr(4'h0, 32'h0000_00A5, 4'hF);
    rd_chk("ctrl_a5", 4'h0, 32'h0000_00A5);
    check_eq("ro_sel_a", 32'(ro_sel), 32'hA);
    check_eq("ro_start_1", 32'(ro_start), 32'h1);
    wb_wr(4'h0, 32'hFFFF_FF31, 4'b0001);
    rd_chk("ctrl_b0", 4'h0, 32'h0000_0031);
    wb_wr(4'h0, 32'hFFFF_FFFF, 4'b0010);
    rd_chk("ctrl_b1_ign", 4'h0, 32'h0000_0031);
    rd_chk("no_go_status", 4'hC, 32'h0);
    wb_wr(4'h4, 32'h1234_5678, 4'hF);
    wb_wr(4'h4, 32'hAAAA_AAAA, 4'b0001);
    rd_chk("gate_b0", 4'h4, 32'h1234_56AA);
    wb_wr(4'h4, 32'h5555_5555, 4'b1000);
    rd_chk("gate_b3", 4'h4, 32'h5534_56AA);

    // Zero gate
    wb_wr(4'h4, 32'h0, 4'hF);
    wb_wr(4'h0, 32'h0000_0007, 4'hF);
    t_go = t_ack;
    wait_irq(t_go, 50, lat);
    check_eq("zero_lat", 32'(lat), 32'd5);
    rd_chk("go_reads0", 4'h0, 32'h0000_0005);
    rd_chk("zero_count", 4'h8, 32'h0);
    rd_chk("zero_status", 4'hC, 32'h2);
    wb_wr(4'hC, 32'h2, 4'hF);
    check_eq("zero_irq_clr", 32'(irq), 0);

    // Nominal: period 10 over 1000 cycles
    ro_half = 5;
    wb_wr(4'h4, 32'd1000, 4'hF);
    wb_wr(4'h0, 32'h0000_0007, 4'hF);
    t_go = t_ack;
    rd_chk("nom_busy", 4'hC, 32'h1);
    wait_irq(t_go, 1200, lat);
    check_eq("nom_lat", 32'(lat), 32'd1005);
    wb_xfer(1'b0, 4'h8, 32'h0, 4'hF, r);
    check_eq("nom_count_rng", 32'(r >= 99 && r <= 101), 32'd1);
    rd_chk("nom_status", 4'hC, 32'h2);
    check_eq("nom_irq", 32'(irq), 32'd1);
    wb_wr(4'hC, 32'h2, 4'hF);
    check_eq("nom_irq_clr", 32'(irq), 0);

    // Overflow: 300 edges into an 8-bit counter
    ro_half = 1;
    wb_wr(4'h4, 32'd600, 4'hF);
    wb_wr(4'h0, 32'h0000_0007, 4'hF);
    t_go = t_ack;
    wait_irq(t_go, 800, lat);
    check_eq("ovf_lat", 32'(lat), 32'd605);
    rd_chk("ovf_count", 4'h8, 32'd255);
    rd_chk("ovf_status", 4'hC, 32'h6);
    wb_wr(4'hC, 32'h6, 4'hF);
    rd_chk("ovf_clr", 4'hC, 32'h0);

    // Lockout while measuring
    ro_half = 5;
    wb_wr(4'h4, 32'd1000, 4'hF);
    wb_wr(4'h0, 32'h0000_0007, 4'hF);
    t_go = t_ack;
    repeat (20) @(posedge clk);
    wb_wr(4'h4, 32'd5, 4'hF);
    wb_wr(4'h0, 32'h0000_0037, 4'hF);
    check_eq("lock_sel", 32'(ro_sel), 0);
    rd_chk("lock_gate", 4'h4, 32'd1000);
    rd_chk("lock_busy", 4'hC, 32'h1);
    wait_irq(t_go, 1200, lat);
    check_eq("lock_lat", 32'(lat), 32'd1005);
    wb_xfer(1'b0, 4'h8, 32'h0, 4'hF, r);
    check_eq("lock_count_rng", 32'(r >= 99 && r <= 101), 32'd1);
    wb_wr(4'hC, 32'h2, 4'hF);

    // Reset mid-measurement
    irq_seen = 0;
    irq_watch = 1;
    wb_wr(4'h0, 32'h0000_0007, 4'hF);
    repeat (50) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check_eq("mid_start", 32'(ro_start), 0);
    rd_chk("mid_status", 4'hC, 32'h0);
    rd_chk("mid_count", 4'h8, 32'h0);
    repeat (1100) @(posedge clk);
    check_eq("mid_no_irq", 32'(irq_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
